// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared constants and helpers for the parametrised sequence detector
package seqdet_pkg;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W = 8;
  function automatic int lenw(input int max_len);
    return $clog2(max_len) + 1;
  endfunction
  function automatic logic [63:0] pat_mask(input int leff);
    return (leff >= 64) ? '1 : (64'(1) << leff) - 64'(1);
  endfunction
endpackage

// File: rtl/seqdet_sat_counter.sv
// seqdet_sat_counter: saturating up-counter with synchronous clear
//   clk: clock, clr: synchronous clear (wins over inc), inc: count enable
//   count: current value, holds at all-ones
module seqdet_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-configurable serial bit-pattern detector
//   clk/rst: rising-edge clock, synchronous active-high reset
//   cfg_load/cfg_pattern/cfg_len/cfg_overlap: configuration captured on cfg_load
//   in_valid/in_bit: qualified serial input
//   match: registered one-cycle hit pulse, fill: bits eligible for the next match
//   match_count: saturating hit count, built only when SEQDET_COUNT_EN is defined (else 0)
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LEN_W = lenw(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   fill
);
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0] len;
  logic ovl;
  // the oldest history bit is shifted out before it can ever be compared, so only MAX_LEN-1 bits are kept
  logic [MAX_LEN-2:0] hist;
  logic [MAX_LEN-1:0] new_hist, mask;
  logic [LEN_W-1:0] leff, fill_nxt;
  logic accept, hit;
  assign leff = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign mask = MAX_LEN'(pat_mask(int'(leff)));
  assign new_hist = {hist, in_bit};
  assign accept = in_valid && !cfg_load;
  assign hit = accept && leff != '0 && (fill + LEN_W'(1)) >= leff && ((new_hist ^ pat) & mask) == '0;
  assign fill_nxt = (hit && !ovl) ? '0 : (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
  always_ff @(posedge clk)
    if (rst) begin
      pat <= '0;
      len <= '0;
      ovl <= 1'b0;
      hist <= '0;
      fill <= '0;
      match <= 1'b0;
    end else if (cfg_load) begin
      pat <= cfg_pattern;
      len <= cfg_len;
      ovl <= cfg_overlap;
      hist <= '0;
      fill <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (in_valid) begin
        hist <= new_hist[MAX_LEN-2:0];
        fill <= fill_nxt;
      end
    end
`ifdef SEQDET_COUNT_EN
  seqdet_sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .clr(rst),
    .inc(hit),
    .count(match_count)
  );
`else
  assign match_count = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: randomized and directed check of seq_detector_param against a bit-queue model
module tb_seq_detector_param;
  import seqdet_pkg::*;
  localparam int ML = 8;
  localparam int CW = 2;
  localparam int LW = lenw(ML);
`ifdef SEQDET_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, cfg_load, cfg_overlap, in_valid, in_bit, match;
  logic [ML-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len, fill;
  logic [CW-1:0] match_count;
  int checks = 0, errors = 0;
  string phase = "reset";
  logic [ML-1:0] m_pat;
  int m_len, m_since, m_cnt;
  bit m_ovl, m_match;
  bit q[$];

  seq_detector_param #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
    .match(match), .match_count(match_count), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int leff;
    bit hit;
    if (rst) begin
      m_pat = '0; m_len = 0; m_ovl = 0; q.delete(); m_since = 0; m_match = 0; m_cnt = 0;
    end else if (cfg_load) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
      q.delete(); m_since = 0; m_match = 0;
    end else if (in_valid) begin
      q.push_back(in_bit);
      if (q.size() > ML) void'(q.pop_front());
      leff = (m_len > ML) ? ML : m_len;
      hit = (leff != 0) && (m_since + 1 >= leff);
      for (int j = 0; j < leff; j++)
        if (hit && q[q.size()-1-j] != m_pat[j]) hit = 0;
      m_match = hit;
      m_since = (hit && !m_ovl) ? 0 : m_since + 1;
      if (hit && m_cnt < (1 << CW) - 1) m_cnt++;
    end else m_match = 0;
  endtask

  task automatic step(input bit r, input bit l, input bit v, input bit b);
    rst = r; cfg_load = l; in_valid = v; in_bit = b;
    @(posedge clk);
    model_edge();
    #1;
    chk("match", 32'(match), 32'(m_match));
    chk("match_count", 32'(match_count), CNT_EN ? 32'(m_cnt) : 32'd0);
    chk("fill", 32'(fill), 32'((m_since > ML) ? ML : m_since));
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(0, 0, 1, s[i] == "1");
  endtask

  task automatic load(input int p, input int n, input bit o);
    cfg_pattern = ML'(p); cfg_len = LW'(n); cfg_overlap = o;
    step(0, 1, 0, 0);
  endtask

  initial begin
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_fill", 32'(fill), 0);
    phase = "disabled";
    send("11011");
    chk("disabled_count", 32'(match_count), 0);
    phase = "overlap";
    load(5'b11011, 5, 1);
    send("11011011");
    chk("ovl_count", 32'(match_count), CNT_EN ? 2 : 0);
    phase = "nonoverlap";
    step(1, 0, 0, 0);
    load(5'b11011, 5, 0);
    send("11011011");
    chk("novl_count", 32'(match_count), CNT_EN ? 1 : 0);
    chk("novl_fill", 32'(fill), 3);
    phase = "gap";
    load(5'b11011, 5, 1);
    send("110");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    send("1");
    chk("gap_nomatch", 32'(match), 0);
    send("1");
    chk("gap_match", 32'(match), 1);
    phase = "load_race";
    load(5'b11011, 5, 1);
    send("1101");
    step(0, 1, 1, 1);
    chk("race_match", 32'(match), 0);
    chk("race_fill", 32'(fill), 0);
    send("1");
    chk("race_after", 32'(match), 0);
    phase = "saturate";
    step(1, 0, 0, 0);
    load(1, 1, 1);
    send("11111");
    chk("sat_count", 32'(match_count), CNT_EN ? 3 : 0);
    phase = "clamp";
    load(8'b10110011, 15, 1);
    send("1011001110110011");
    chk("clamp_match", 32'(match), 1);
    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      bit r, l;
      r = $urandom_range(0, 499) == 0;
      l = $urandom_range(0, 39) == 0;
      if (l) begin
        cfg_pattern = ML'($urandom);
        cfg_len = LW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4));
        cfg_overlap = 1'($urandom);
      end
      step(r, l, $urandom_range(0, 3) != 0, 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
